// File: rtl/dispatch_source.sv
// Byte-stream instruction decoder: assembles RUN/SPK/SNC/CLR instructions from the
// host link and executes them on the network core, back-pressuring the link meanwhile.
module dispatch_source #(
    parameter  int unsigned NUM_INP = 8,
    parameter  int unsigned CHG_W   = 8,
    parameter  int unsigned RUN_W   = 16,
    localparam int unsigned IDX_W   = (NUM_INP > 1) ? $clog2(NUM_INP) : 1
) (
    input  logic             clk,
    input  logic             arstn,
    input  logic [7:0]       rx_data,
    input  logic             rx_valid,
    output logic             rx_ready,
    output logic             net_inp_en,
    output logic [IDX_W-1:0] net_inp_idx,
    output logic [CHG_W-1:0] net_inp_chg,
    output logic             net_run,
    output logic             net_clr,
    output logic [1:0]       snk_flags,
    output logic             snk_valid,
    input  logic             snk_ready,
    output logic             err_idx
);

    localparam int unsigned SPK_B = (2 + IDX_W + CHG_W + 7) / 8;
    localparam int unsigned RUN_B = (2 + RUN_W + 7) / 8;
    localparam int unsigned MAX_B = (SPK_B > RUN_B) ? SPK_B : RUN_B;
    localparam int unsigned SH_W  = MAX_B * 8;
    localparam int unsigned BC_W  = $clog2(MAX_B + 1);

    typedef enum logic [1:0] {OP_RUN = 2'd0, OP_SPK = 2'd1, OP_SNC = 2'd2, OP_CLR = 2'd3} op_t;
    typedef enum logic [1:0] {S_HDR, S_PAY, S_EXEC} state_t;

    state_t            state;
    op_t               op;
    logic [BC_W-1:0]   rem;
    logic [SH_W-9:0]   sh;
    logic [RUN_W-1:0]  cnt;

    logic              acc_c;
    logic              last_c;
    op_t               op_in_c;
    op_t               op_nxt_c;
    logic [SH_W-1:0]   word_c;
    logic [IDX_W-1:0]  spk_idx_c;
    logic [CHG_W-1:0]  spk_chg_c;
    logic [RUN_W-1:0]  run_cnt_c;
    logic              in_range_c;
    logic              unused_word;

    function automatic logic [BC_W-1:0] op_bytes(input op_t o);
        case (o)
            OP_SPK:  op_bytes = BC_W'(SPK_B);
            OP_RUN:  op_bytes = BC_W'(RUN_B);
            default: op_bytes = BC_W'(1);
        endcase
    endfunction

    // Instruction word as it stands once the current byte is shifted in.
    assign word_c      = {sh, rx_data};
    assign acc_c       = rx_valid && rx_ready;
    assign op_in_c     = op_t'(rx_data[7:6]);
    assign op_nxt_c    = (state == S_HDR) ? op_in_c : op;
    assign last_c      = acc_c && (((state == S_HDR) && (op_bytes(op_in_c) == BC_W'(1))) ||
                                   ((state == S_PAY) && (rem == BC_W'(1))));
    assign spk_idx_c   = word_c[SPK_B*8-3 -: IDX_W];
    assign spk_chg_c   = word_c[SPK_B*8-3-IDX_W -: CHG_W];
    assign run_cnt_c   = word_c[RUN_B*8-3 -: RUN_W];
    assign in_range_c  = ({1'b0, spk_idx_c} < (IDX_W+1)'(NUM_INP));
    assign unused_word = ^word_c;

    // Steps are gated by the sink so the output side never drops a timestep.
    assign net_run = (state == S_EXEC) && (op == OP_RUN) && (cnt != '0) && snk_ready;

    always_ff @(posedge clk or negedge arstn) begin
        if (!arstn) begin
            state       <= S_HDR;
            op          <= OP_RUN;
            rem         <= '0;
            sh          <= '0;
            cnt         <= '0;
            rx_ready    <= 1'b1;
            net_inp_en  <= 1'b0;
            net_inp_idx <= '0;
            net_inp_chg <= '0;
            net_clr     <= 1'b0;
            snk_flags   <= 2'b00;
            snk_valid   <= 1'b0;
            err_idx     <= 1'b0;
        end else begin
            net_inp_en <= 1'b0;
            net_clr    <= 1'b0;
            if (acc_c) sh <= word_c[SH_W-9:0];

            case (state)
                S_HDR: begin
                    if (acc_c) begin
                        op    <= op_in_c;
                        rem   <= op_bytes(op_in_c) - BC_W'(1);
                        state <= S_PAY;
                    end
                end
                S_PAY: begin
                    if (acc_c) rem <= rem - BC_W'(1);
                end
                S_EXEC: begin
                    case (op)
                        OP_SPK: begin
                            state    <= S_HDR;
                            rx_ready <= 1'b1;
                        end
                        OP_RUN: begin
                            if (snk_ready && (cnt != '0)) cnt <= cnt - RUN_W'(1);
                            if ((cnt == '0) || (snk_ready && (cnt == RUN_W'(1)))) begin
                                state    <= S_HDR;
                                rx_ready <= 1'b1;
                            end
                        end
                        default: begin
                            if (snk_ready) begin
                                snk_valid <= 1'b0;
                                snk_flags <= 2'b00;
                                state     <= S_HDR;
                                rx_ready  <= 1'b1;
                            end
                        end
                    endcase
                end
                default: state <= S_HDR;
            endcase

            // Final byte: launch execution so its first effect lands in the next cycle.
            if (last_c) begin
                state    <= S_EXEC;
                rx_ready <= 1'b0;
                case (op_nxt_c)
                    OP_SPK: begin
                        if (in_range_c) begin
                            net_inp_en  <= 1'b1;
                            net_inp_idx <= spk_idx_c;
                            net_inp_chg <= spk_chg_c;
                        end else begin
                            err_idx <= 1'b1;
                        end
                    end
                    OP_RUN: cnt <= run_cnt_c;
                    OP_SNC: begin
                        snk_valid <= 1'b1;
                        snk_flags <= 2'b01;
                    end
                    default: begin
                        net_clr   <= 1'b1;
                        snk_valid <= 1'b1;
                        snk_flags <= 2'b10;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_dispatch_source.sv
// Directed bench for dispatch_source; NUM_INP=6 so out-of-range indices are encodable.
module tb_dispatch_source;

    localparam int unsigned NUM_INP = 6;
    localparam int unsigned CHG_W   = 8;
    localparam int unsigned RUN_W   = 16;
    localparam int unsigned IDX_W   = 3;

    logic             clk = 1'b0;
    logic             arstn;
    logic [7:0]       rx_data;
    logic             rx_valid;
    logic             rx_ready;
    logic             net_inp_en;
    logic [IDX_W-1:0] net_inp_idx;
    logic [CHG_W-1:0] net_inp_chg;
    logic             net_run;
    logic             net_clr;
    logic [1:0]       snk_flags;
    logic             snk_valid;
    logic             snk_ready;
    logic             err_idx;

    int n_chk  = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    dispatch_source #(.NUM_INP(NUM_INP), .CHG_W(CHG_W), .RUN_W(RUN_W)) dut (
        .clk(clk), .arstn(arstn),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
        .net_inp_en(net_inp_en), .net_inp_idx(net_inp_idx), .net_inp_chg(net_inp_chg),
        .net_run(net_run), .net_clr(net_clr),
        .snk_flags(snk_flags), .snk_valid(snk_valid), .snk_ready(snk_ready),
        .err_idx(err_idx)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Present one byte from a negedge; returns at the negedge after it is accepted.
    task automatic send(input logic [7:0] b);
        int n;
        n = 0;
        rx_data  = b;
        rx_valid = 1'b1;
        while (!rx_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) check("send_timeout", 32'(n), 32'(0));
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    task automatic check_quiet(input string tag);
        check({tag, "_rx_ready"}, 32'(rx_ready), 32'(1));
        check({tag, "_inp_en"},   32'(net_inp_en), 32'(0));
        check({tag, "_run"},      32'(net_run), 32'(0));
        check({tag, "_clr"},      32'(net_clr), 32'(0));
        check({tag, "_valid"},    32'(snk_valid), 32'(0));
        check({tag, "_flags"},    32'(snk_flags), 32'(0));
    endtask

    initial begin
        int runs;
        logic [3:0] pat;
        arstn     = 1'b0;
        rx_data   = 8'h00;
        rx_valid  = 1'b0;
        snk_ready = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        check_quiet("rst");
        check("rst_err", 32'(err_idx), 32'(0));
        check("rst_idx", 32'(net_inp_idx), 32'(0));
        check("rst_chg", 32'(net_inp_chg), 32'(0));
        @(negedge clk);
        arstn = 1'b1;
        @(negedge clk);

        // Reset while a RUN payload is half-received
        send(8'h00);
        send(8'h00);
        arstn = 1'b0;
        #1;
        check_quiet("midrst");
        @(negedge clk);
        arstn     = 1'b1;
        snk_ready = 1'b1;
        @(negedge clk);
        send(8'h80);
        check("midrst_snc_valid", 32'(snk_valid), 32'(1));
        check("midrst_snc_flags", 32'(snk_flags), 32'(1));
        check("midrst_snc_busy",  32'(rx_ready), 32'(0));
        check("midrst_snc_run",   32'(net_run), 32'(0));
        @(negedge clk);
        check_quiet("midrst_done");

        // SPK idx=5 chg=0x7F
        send(8'h6B);
        check("spk_pay_en", 32'(net_inp_en), 32'(0));
        check("spk_pay_rdy", 32'(rx_ready), 32'(1));
        send(8'hF8);
        check("spk_en",  32'(net_inp_en), 32'(1));
        check("spk_idx", 32'(net_inp_idx), 32'(5));
        check("spk_chg", 32'(net_inp_chg), 32'h7F);
        check("spk_err", 32'(err_idx), 32'(0));
        check("spk_busy", 32'(rx_ready), 32'(0));
        @(negedge clk);
        check("spk_en_off", 32'(net_inp_en), 32'(0));
        check("spk_idx_hold", 32'(net_inp_idx), 32'(5));
        check("spk_chg_hold", 32'(net_inp_chg), 32'h7F);
        check("spk_rdy_back", 32'(rx_ready), 32'(1));

        // RUN 3 with snk_ready 1,0,1,1
        pat = 4'b1101;
        runs = 0;
        send(8'h00);
        send(8'h00);
        send(8'hC0);
        for (int i = 0; i < 4; i++) begin
            snk_ready = pat[i];
            #1;
            check($sformatf("run3_step%0d", i), 32'(net_run), 32'(pat[i]));
            check($sformatf("run3_busy%0d", i), 32'(rx_ready), 32'(0));
            if (net_run) runs++;
            @(negedge clk);
        end
        snk_ready = 1'b1;
        #1;
        check("run3_total", 32'(runs), 32'(3));
        check_quiet("run3_done");
        @(negedge clk);

        // RUN 0
        send(8'h00);
        send(8'h00);
        send(8'h00);
        #1;
        check("run0_run", 32'(net_run), 32'(0));
        check("run0_busy", 32'(rx_ready), 32'(0));
        @(negedge clk);
        #1;
        check_quiet("run0_done");
        @(negedge clk);

        // SNC held by sink for 4 cycles
        snk_ready = 1'b0;
        send(8'h80);
        for (int i = 0; i < 5; i++) begin
            snk_ready = (i == 4);
            #1;
            check($sformatf("snc_valid%0d", i), 32'(snk_valid), 32'(1));
            check($sformatf("snc_flags%0d", i), 32'(snk_flags), 32'(1));
            check($sformatf("snc_busy%0d", i), 32'(rx_ready), 32'(0));
            @(negedge clk);
        end
        #1;
        check_quiet("snc_done");
        @(negedge clk);

        // CLR then SNC with rx_valid held high
        rx_data  = 8'hC0;
        rx_valid = 1'b1;
        @(negedge clk);
        rx_data = 8'h80;
        #1;
        check("clr_pulse", 32'(net_clr), 32'(1));
        check("clr_valid", 32'(snk_valid), 32'(1));
        check("clr_flags", 32'(snk_flags), 32'(2));
        check("clr_busy",  32'(rx_ready), 32'(0));
        @(negedge clk);
        #1;
        check("clr_pulse_off", 32'(net_clr), 32'(0));
        check("clr_valid_off", 32'(snk_valid), 32'(0));
        check("clr_rdy_back",  32'(rx_ready), 32'(1));
        @(negedge clk);
        rx_valid = 1'b0;
        #1;
        check("b2b_snc_valid", 32'(snk_valid), 32'(1));
        check("b2b_snc_flags", 32'(snk_flags), 32'(1));
        check("b2b_snc_clr",   32'(net_clr), 32'(0));
        @(negedge clk);
        #1;
        check_quiet("b2b_done");
        @(negedge clk);
        #1;
        check_quiet("b2b_no_replay");

        // Out-of-range SPK: idx 6 (first invalid), then idx 7
        send(8'h70);
        send(8'h00);
        check("oor6_en",  32'(net_inp_en), 32'(0));
        check("oor6_err", 32'(err_idx), 32'(1));
        check("oor6_idx_hold", 32'(net_inp_idx), 32'(5));
        @(negedge clk);
        send(8'h78);
        send(8'h90);
        check("oor7_en",  32'(net_inp_en), 32'(0));
        check("oor7_err", 32'(err_idx), 32'(1));
        @(negedge clk);
        // Valid SPK idx 2 chg 0x80 afterwards: error stays sticky
        send(8'h54);
        send(8'h00);
        check("spk2_en",  32'(net_inp_en), 32'(1));
        check("spk2_idx", 32'(net_inp_idx), 32'(2));
        check("spk2_chg", 32'(net_inp_chg), 32'h80);
        check("spk2_err_sticky", 32'(err_idx), 32'(1));
        @(negedge clk);
        arstn = 1'b0;
        #1;
        check("err_cleared", 32'(err_idx), 32'(0));
        check_quiet("final_rst");
        @(negedge clk);
        arstn = 1'b1;
        @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
